// File: rtl/sdram_refresh_sched.sv
// Refresh scheduler: counts refresh intervals, tracks owed refreshes as debt and
// issues them through a refresh/refresh_ack handshake when idle or when urgent.
module sdram_refresh_sched #(
  parameter int INTERVAL = 780,
  parameter int MAX_DEBT = 8,
  parameter int URGENT   = 6,
  localparam int DEBT_W  = $clog2(MAX_DEBT + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              idle,
  output logic              refresh,
  input  logic              refresh_ack,
  output logic [DEBT_W-1:0] debt,
  output logic              urgent,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(INTERVAL - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX  = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] DEBT_URG  = DEBT_W'(URGENT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEBT_W-1:0]  debt_q, debt_d;
  logic               overflow_q, overflow_d;
  logic               refresh_q, refresh_d;
  logic               tick;
  logic               dec;
  logic               ovf_set;

  assign urgent   = (debt_q >= DEBT_URG);
  assign debt     = debt_q;
  assign overflow = overflow_q;
  assign refresh  = refresh_q;

  always_comb begin
    cnt_d      = cnt_q;
    tick       = 1'b0;
    debt_d     = debt_q;
    ovf_set    = 1'b0;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // An ack only counts while a request is outstanding; a tick and an ack in
    // the same cycle cancel, so saturation is not flagged in that case.
    dec = (state_q == S_REQ) && refresh_ack;

    if (tick && !dec) begin
      if (debt_q == DEBT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        debt_d = debt_q + DEBT_W'(1);
      end
    end else if (dec && !tick) begin
      debt_d = debt_q - DEBT_W'(1);
    end

    if (clr_overflow) begin
      overflow_d = 1'b0;
    end else if (ovf_set) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if ((debt_q != '0) && (idle || urgent)) state_d = S_REQ;
      S_REQ:  if (refresh_ack) state_d = S_GAP;
      S_GAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    refresh_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      debt_q     <= '0;
      overflow_q <= 1'b0;
      refresh_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      debt_q     <= debt_d;
      overflow_q <= overflow_d;
      refresh_q  <= refresh_d;
    end
  end

endmodule
